sum_squares_accum: RTL

SUM_SQUARES_ACCUM -- requirements
Module: sum_squares_accum

---
 rtl/sum_squares_accum_if.sv | 40 ++++
 rtl/sum_squares_accum.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sum_squares_accum_if.sv
// ---------------------------------------------------------------------------
// sum_squares_accum_if
//
// Purpose: bundles the sample stream, window control and result signals of
// the sum-of-squares accumulator into one interface.
//
// Signals:
//   sample_in       SAMPLE_WIDTH  two's-complement sample (master -> slave)
//   sample_valid    1             qualifies sample_in, no backpressure
//   win_len         COUNT_WIDTH   requested samples per window
//   flush           1             closes the current partial window
//   numerator_out   SUM_WIDTH     sum of squares of the closed window
//   denominator_out COUNT_WIDTH   number of samples in the closed window
//   valid_out       1             single-cycle pulse qualifying the results
//
// Modports: master drives the stream and reads results, slave is the block.
// ---------------------------------------------------------------------------
interface sum_squares_accum_if #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int COUNT_WIDTH  = 8,
    parameter int SUM_WIDTH    = 72
);
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_valid;
    logic [COUNT_WIDTH-1:0]  win_len;
    logic                    flush;
    logic [SUM_WIDTH-1:0]    numerator_out;
    logic [COUNT_WIDTH-1:0]  denominator_out;
    logic                    valid_out;

    modport master (
        output sample_in, sample_valid, win_len, flush,
        input  numerator_out, denominator_out, valid_out
    );

    modport slave (
        input  sample_in, sample_valid, win_len, flush,
        output numerator_out, denominator_out, valid_out
    );
endinterface

// File: rtl/sum_squares_accum.sv
// ---------------------------------------------------------------------------
// sum_squares_accum
//
// Purpose: two-stage pipeline that squares signed samples and accumulates
// them over windows of win_len samples (0 treated as 1). Each closed window
// produces a numerator (sum of squares) and denominator (sample count) with
// a single-cycle valid_out pulse two cycles after the last sample. flush
// travels with the stage-1 sample and closes a partial window early.
//
// Ports:
//   clk  input   rising-edge clock
//   rst  input   synchronous active-high reset
//   bus  slave   sum_squares_accum_if (stream in, results out)
// ---------------------------------------------------------------------------
module sum_squares_accum #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int COUNT_WIDTH  = 8,
    parameter int SUM_WIDTH    = 72
) (
    input  logic                   clk,
    input  logic                   rst,
    sum_squares_accum_if.slave     bus
);
    localparam int SQ_WIDTH = 2 * SAMPLE_WIDTH;

    // Stage 1 registers
    logic                   s1ValidQ, s1ValidD;
    logic                   s1FlushQ, s1FlushD;
    logic [SQ_WIDTH-1:0]    sqQ, sqD;

    // Stage 2 registers
    logic [SUM_WIDTH-1:0]   accQ, accD;
    logic [COUNT_WIDTH-1:0] countQ, countD;
    logic [COUNT_WIDTH-1:0] lenQ, lenD;
    logic [SUM_WIDTH-1:0]   numQ, numD;
    logic [COUNT_WIDTH-1:0] denQ, denD;
    logic                   validQ, validD;

    logic signed [SQ_WIDTH-1:0] sampleExt;
    logic [COUNT_WIDTH-1:0]     winLenSat;
    logic [COUNT_WIDTH-1:0]     effLen;
    logic [SUM_WIDTH-1:0]       sumNext;
    logic [COUNT_WIDTH-1:0]     countNext;

    // Stage 1: sign-extend before multiplying so the square is exact; the
    // product of a value with itself is never negative, so it is taken as
    // unsigned. flush is registered independently of sample_valid so a
    // flush-alone cycle still reaches stage 2.
    always_comb begin
        sampleExt = SQ_WIDTH'($signed(bus.sample_in));
        sqD       = SQ_WIDTH'(sampleExt * sampleExt);
        s1ValidD  = bus.sample_valid;
        s1FlushD  = bus.flush;
    end

    // Stage 2: the window length is sampled only when a sample lands in an
    // empty window, so later win_len changes cannot disturb an open window.
    // The accumulator is already zero when the window is empty, so the sum
    // needs no special case for the first sample.
    always_comb begin
        accD      = accQ;
        countD    = countQ;
        lenD      = lenQ;
        numD      = numQ;
        denD      = denQ;
        validD    = 1'b0;
        winLenSat = (bus.win_len == '0) ? COUNT_WIDTH'(1) : bus.win_len;
        effLen    = (countQ == '0) ? winLenSat : lenQ;
        sumNext   = accQ + SUM_WIDTH'(sqQ);
        countNext = countQ + COUNT_WIDTH'(1);

        if (s1ValidQ) begin
            lenD = effLen;
            if ((countNext == effLen) || s1FlushQ) begin
                numD   = sumNext;
                denD   = countNext;
                validD = 1'b1;
                accD   = '0;
                countD = '0;
            end else begin
                accD   = sumNext;
                countD = countNext;
            end
        end else if (s1FlushQ && (countQ != '0)) begin
            numD   = accQ;
            denD   = countQ;
            validD = 1'b1;
            accD   = '0;
            countD = '0;
        end
    end

    // State registers; reset discards any open window without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1ValidQ <= 1'b0;
            s1FlushQ <= 1'b0;
            sqQ      <= '0;
            accQ     <= '0;
            countQ   <= '0;
            lenQ     <= '0;
            numQ     <= '0;
            denQ     <= '0;
            validQ   <= 1'b0;
        end else begin
            s1ValidQ <= s1ValidD;
            s1FlushQ <= s1FlushD;
            sqQ      <= sqD;
            accQ     <= accD;
            countQ   <= countD;
            lenQ     <= lenD;
            numQ     <= numD;
            denQ     <= denD;
            validQ   <= validD;
        end
    end

    assign bus.numerator_out   = numQ;
    assign bus.denominator_out = denQ;
    assign bus.valid_out       = validQ;
endmodule
